// File: rtl/kb_scr_link_pkg.sv
// Shared definitions for the keyboard/screen link pair.
// Used by kb_scr_link and its CPU-side partner kb_scr_drv.
package kb_scr_link_pkg;

    localparam int LNK_W = 8;
    localparam int CNT_W = 5;

    localparam int SCR_REQ = 0;
    localparam int KB_ACK  = 1;
    localparam int KB_REQ  = 0;
    localparam int SCR_ACK = 1;

    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_REQ,
        TX_WAIT
    } tx_state_e;

endpackage

// File: rtl/kb_scr_link_fifo.sv
// Circular byte FIFO with a registered head and wrap-bit pointers.
// Push while full is only accepted alongside a valid pop.
module link_byte_fifo
    import kb_scr_link_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             i_push,
    input  logic [LNK_W-1:0] i_wdata,
    input  logic             i_pop,
    output logic [LNK_W-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [LNK_W-1:0] r_mem [DEPTH];
    logic [LNK_W-1:0] r_head;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [AW:0]      w_rptr_nxt;
    logic [LNK_W-1:0] w_head_nxt;

    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign o_count = CNT_W'(r_wptr - r_rptr);
    assign o_head  = r_head;

    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || w_pop_ok);
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop_ok};

    // The slot being written becomes the head when the FIFO is
    // otherwise empty after this cycle's pop.
    assign w_head_nxt =
        (w_push_ok && (r_wptr[AW-1:0] == w_rptr_nxt[AW-1:0])) ?
        i_wdata : r_mem[w_rptr_nxt[AW-1:0]];

    always_ff @(posedge Clock) begin
        if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_head <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            r_rptr <= w_rptr_nxt;
            if (w_push_ok || w_pop_ok) begin
                r_head <= w_head_nxt;
            end
        end
    end

endmodule

// File: rtl/kb_scr_link.sv
// Peripheral end of the keyboard/screen byte link: two four-phase
// req/ack channels, each buffered by a byte FIFO.
module kb_scr_link
    import kb_scr_link_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [LNK_W-1:0] lnk_data_i,
    input  logic [1:0]       lnk_ctrl_i,
    output logic [LNK_W-1:0] lnk_data_o,
    output logic [1:0]       lnk_ctrl_o,
    output logic [LNK_W-1:0] scr_byte,
    output logic             scr_valid,
    input  logic             scr_ready,
    input  logic [LNK_W-1:0] kb_byte,
    input  logic             kb_valid,
    output logic             kb_ready,
    output logic [CNT_W-1:0] scr_count,
    output logic [CNT_W-1:0] kb_count
);

    logic [1:0]       r_sync [SYNC_STAGES];
    rx_state_e        r_rx_state;
    rx_state_e        w_rx_nxt;
    tx_state_e        r_tx_state;
    tx_state_e        w_tx_nxt;
    logic             r_scr_ack;
    logic             r_kb_req;
    logic [LNK_W-1:0] r_lnk_data;
    logic             r_kb_en;

    logic             w_scr_req;
    logic             w_kb_ack;
    logic             w_scr_push;
    logic             w_scr_full;
    logic             w_scr_empty;
    logic             w_kb_push;
    logic             w_kb_pop;
    logic             w_kb_full;
    logic             w_kb_empty;
    logic             w_tx_load;
    logic [LNK_W-1:0] w_kb_head;

    // Only the control lines cross domains; data is qualified by req.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= lnk_ctrl_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_scr_req = r_sync[SYNC_STAGES-1][SCR_REQ];
    assign w_kb_ack  = r_sync[SYNC_STAGES-1][KB_ACK];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rx_state <= RX_IDLE;
            r_tx_state <= TX_IDLE;
        end else begin
            r_rx_state <= w_rx_nxt;
            r_tx_state <= w_tx_nxt;
        end
    end

    always_comb begin
        w_rx_nxt   = r_rx_state;
        w_scr_push = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (w_scr_req && !w_scr_full) begin
                    w_rx_nxt   = RX_ACK;
                    w_scr_push = 1'b1;
                end
            end
            RX_ACK: begin
                if (!w_scr_req) begin
                    w_rx_nxt = RX_IDLE;
                end
            end
            default: w_rx_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        w_tx_nxt  = r_tx_state;
        w_tx_load = 1'b0;
        w_kb_pop  = 1'b0;
        unique case (r_tx_state)
            TX_IDLE: begin
                if (!w_kb_empty) begin
                    w_tx_nxt  = TX_SETUP;
                    w_tx_load = 1'b1;
                end
            end
            TX_SETUP: w_tx_nxt = TX_REQ;
            TX_REQ: begin
                if (w_kb_ack) begin
                    w_tx_nxt = TX_WAIT;
                    w_kb_pop = 1'b1;
                end
            end
            TX_WAIT: begin
                if (!w_kb_ack) begin
                    w_tx_nxt = TX_IDLE;
                end
            end
            default: w_tx_nxt = TX_IDLE;
        endcase
    end

    // Link outputs come straight from flops so the far side sees no glitches.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_scr_ack  <= 1'b0;
            r_kb_req   <= 1'b0;
            r_lnk_data <= '0;
            r_kb_en    <= 1'b0;
        end else begin
            r_scr_ack <= (w_rx_nxt == RX_ACK);
            r_kb_req  <= (w_tx_nxt == TX_REQ);
            r_kb_en   <= 1'b1;
            if (w_tx_load) begin
                r_lnk_data <= w_kb_head;
            end
        end
    end

    always_comb begin
        lnk_ctrl_o          = '0;
        lnk_ctrl_o[KB_REQ]  = r_kb_req;
        lnk_ctrl_o[SCR_ACK] = r_scr_ack;
    end

    assign lnk_data_o = r_lnk_data;
    assign scr_valid  = !w_scr_empty;
    assign kb_ready   = r_kb_en && !w_kb_full;
    assign w_kb_push  = kb_valid && kb_ready;

    link_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_scr_fifo (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .i_push  (w_scr_push),
        .i_wdata (lnk_data_i),
        .i_pop   (scr_ready),
        .o_head  (scr_byte),
        .o_full  (w_scr_full),
        .o_empty (w_scr_empty),
        .o_count (scr_count)
    );

    link_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_kb_fifo (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .i_push  (w_kb_push),
        .i_wdata (kb_byte),
        .i_pop   (w_kb_pop),
        .o_head  (w_kb_head),
        .o_full  (w_kb_full),
        .o_empty (w_kb_empty),
        .o_count (kb_count)
    );

endmodule
